// File: rtl/rip_bp_update_ctrl_pkg.sv
// Shared branch-predictor constants: table geometry, weight encodings,
// controller state type and the saturating weight update rule.
package rip_branch_predictor_const;

  localparam int unsigned TABLE_DEPTH = 10;

  typedef logic [TABLE_DEPTH-1:0] bp_index_t;

  typedef enum logic [2:0] {
    STRONGLY_UNTAKEN = 3'd0,
    WEAKLY_UNTAKEN   = 3'd1,
    WEAKLY_TAKEN     = 3'd2,
    STRONGLY_TAKEN   = 3'd3,
    NONE             = 3'd4
  } bp_weight_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } bp_ctrl_state_t;

  function automatic bp_weight_t bp_next_weight(input bp_weight_t w, input logic actual);
    case (w)
      STRONGLY_UNTAKEN: bp_next_weight = actual ? WEAKLY_UNTAKEN : STRONGLY_UNTAKEN;
      WEAKLY_UNTAKEN:   bp_next_weight = actual ? WEAKLY_TAKEN   : STRONGLY_UNTAKEN;
      WEAKLY_TAKEN:     bp_next_weight = actual ? STRONGLY_TAKEN : WEAKLY_UNTAKEN;
      STRONGLY_TAKEN:   bp_next_weight = actual ? STRONGLY_TAKEN : WEAKLY_TAKEN;
      default:          bp_next_weight = WEAKLY_UNTAKEN;
    endcase
  endfunction

endpackage

// File: rtl/rip_bp_update_ctrl_if.sv
// Update-side and table-write-side signals of the pattern-table update controller.
interface rip_bp_update_ctrl_if #(
  parameter int unsigned TABLE_DEPTH = rip_branch_predictor_const::TABLE_DEPTH
) ();
  import rip_branch_predictor_const::*;

  logic                   upd_valid;
  logic                   upd_ready;
  logic [TABLE_DEPTH-1:0] upd_index;
  bp_weight_t             upd_weight;
  logic                   upd_actual;
  logic                   flush_req;
  logic                   busy;
  logic                   tbl_we;
  logic [TABLE_DEPTH-1:0] tbl_addr;
  bp_weight_t             tbl_wdata;
  logic [31:0]            mispred_cnt;

  modport master (
    output upd_valid, upd_index, upd_weight, upd_actual, flush_req,
    input  upd_ready, busy, tbl_we, tbl_addr, tbl_wdata, mispred_cnt
  );

  modport slave (
    input  upd_valid, upd_index, upd_weight, upd_actual, flush_req,
    output upd_ready, busy, tbl_we, tbl_addr, tbl_wdata, mispred_cnt
  );
endinterface

// File: rtl/rip_bp_update_ctrl_fifo.sv
// Synchronous FIFO with async reset and a synchronous clear; DEPTH must be a power of two.
module rip_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AW:0] ptr_t;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + ptr_t'(do_push);
    rd_ptr_d = rd_ptr_q + ptr_t'(do_pop);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/rip_bp_update_ctrl.sv
// Pattern-table write controller: queues resolved-branch updates, drains one per
// cycle to the table write port, sweeps the table after reset/flush, counts mispredicts.
module rip_bp_update_ctrl
  import rip_branch_predictor_const::*;
#(
  parameter int unsigned TABLE_DEPTH = rip_branch_predictor_const::TABLE_DEPTH,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  rip_bp_update_ctrl_if.slave bus
);
  localparam int unsigned WW = $bits(bp_weight_t);
  localparam int unsigned DW = TABLE_DEPTH + WW;

  bp_ctrl_state_t         state_q, state_d;
  logic [TABLE_DEPTH-1:0] clr_idx_q, clr_idx_d;
  logic [31:0]            mispred_cnt_q, mispred_cnt_d;

  logic          push, pop, fifo_clr, fifo_full, fifo_empty;
  logic [DW-1:0] push_data, pop_data;
  logic          pred_taken;

  rip_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    mispred_cnt_d = mispred_cnt_q;
    fifo_clr      = 1'b0;
    pop           = 1'b0;
    bus.upd_ready = 1'b0;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = WEAKLY_UNTAKEN;

    case (state_q)
      CLEAR: begin
        bus.tbl_we   = 1'b1;
        bus.tbl_addr = clr_idx_q;
        clr_idx_d    = clr_idx_q + TABLE_DEPTH'(1);
        if (clr_idx_q == '1) state_d = RUN;
        if (bus.flush_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        bus.upd_ready = !fifo_full;
        bus.tbl_we    = !fifo_empty;
        bus.tbl_addr  = pop_data[DW-1:WW];
        bus.tbl_wdata = bp_weight_t'(pop_data[WW-1:0]);
        pop           = !fifo_empty;
        // The head write still lands this cycle; everything queued behind it is stale.
        if (bus.flush_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          fifo_clr  = 1'b1;
        end
      end
    endcase

    push       = bus.upd_valid && bus.upd_ready;
    push_data  = {bus.upd_index, bp_next_weight(bus.upd_weight, bus.upd_actual)};
    pred_taken = (bus.upd_weight >= WEAKLY_TAKEN);
    if (push && (pred_taken != bus.upd_actual) && (mispred_cnt_q != '1))
      mispred_cnt_d = mispred_cnt_q + 32'd1;

    bus.busy        = (state_q == CLEAR);
    bus.mispred_cnt = mispred_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CLEAR;
      clr_idx_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
endmodule

// File: tb/tb_rip_bp_update_ctrl.sv
// Directed bench for rip_bp_update_ctrl at TABLE_DEPTH=4, FIFO_DEPTH=4.
module tb_rip_bp_update_ctrl;
  import rip_branch_predictor_const::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  rip_bp_update_ctrl_if #(.TABLE_DEPTH(4)) bus ();

  rip_bp_update_ctrl #(
    .TABLE_DEPTH (4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] idx, input bp_weight_t w, input logic act);
    bus.upd_valid  = v;
    bus.upd_index  = idx;
    bus.upd_weight = w;
    bus.upd_actual = act;
  endtask

  bp_weight_t  vw   [9];
  logic        va   [9];
  bp_weight_t  vexp [9];
  logic [31:0] vcnt [9];

  initial begin
    vw[0] = STRONGLY_UNTAKEN; va[0] = 0; vexp[0] = STRONGLY_UNTAKEN; vcnt[0] = 1;
    vw[1] = STRONGLY_UNTAKEN; va[1] = 1; vexp[1] = WEAKLY_UNTAKEN;   vcnt[1] = 2;
    vw[2] = WEAKLY_UNTAKEN;   va[2] = 0; vexp[2] = STRONGLY_UNTAKEN; vcnt[2] = 2;
    vw[3] = WEAKLY_UNTAKEN;   va[3] = 1; vexp[3] = WEAKLY_TAKEN;     vcnt[3] = 3;
    vw[4] = WEAKLY_TAKEN;     va[4] = 0; vexp[4] = WEAKLY_UNTAKEN;   vcnt[4] = 4;
    vw[5] = WEAKLY_TAKEN;     va[5] = 1; vexp[5] = STRONGLY_TAKEN;   vcnt[5] = 4;
    vw[6] = STRONGLY_TAKEN;   va[6] = 0; vexp[6] = WEAKLY_TAKEN;     vcnt[6] = 5;
    vw[7] = STRONGLY_TAKEN;   va[7] = 1; vexp[7] = STRONGLY_TAKEN;   vcnt[7] = 5;
    vw[8] = NONE;             va[8] = 1; vexp[8] = WEAKLY_UNTAKEN;   vcnt[8] = 5;

    drive(1'b0, 4'd0, STRONGLY_UNTAKEN, 1'b0);
    bus.flush_req = 1'b0;

    // Reset values
    #2;
    chk("rst_busy",  32'(bus.busy), 32'd1);
    chk("rst_we",    32'(bus.tbl_we), 32'd1);
    chk("rst_addr",  32'(bus.tbl_addr), 32'd0);
    chk("rst_wdata", 32'(bus.tbl_wdata), 32'(WEAKLY_UNTAKEN));
    chk("rst_ready", 32'(bus.upd_ready), 32'd0);
    chk("rst_cnt",   bus.mispred_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Clear sweep: 16 cycles, addresses 0..15
    for (int i = 0; i < 16; i++) begin
      chk("sweep_busy",  32'(bus.busy), 32'd1);
      chk("sweep_we",    32'(bus.tbl_we), 32'd1);
      chk("sweep_addr",  32'(bus.tbl_addr), 32'(i));
      chk("sweep_wdata", 32'(bus.tbl_wdata), 32'(WEAKLY_UNTAKEN));
      tick();
    end
    chk("post_sweep_busy",  32'(bus.busy), 32'd0);
    chk("post_sweep_ready", 32'(bus.upd_ready), 32'd1);
    chk("post_sweep_we",    32'(bus.tbl_we), 32'd0);

    // Single update, one-cycle latency, mispredict
    drive(1'b1, 4'd5, WEAKLY_TAKEN, 1'b0);
    tick();
    drive(1'b0, 4'd0, STRONGLY_UNTAKEN, 1'b0);
    chk("single_we",    32'(bus.tbl_we), 32'd1);
    chk("single_addr",  32'(bus.tbl_addr), 32'd5);
    chk("single_wdata", 32'(bus.tbl_wdata), 32'(WEAKLY_UNTAKEN));
    chk("single_cnt",   bus.mispred_cnt, 32'd1);
    tick();
    chk("single_drained", 32'(bus.tbl_we), 32'd0);

    // Full transition table plus an illegal encoding
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'(i + 1), vw[i], va[i]);
      tick();
      drive(1'b0, 4'd0, STRONGLY_UNTAKEN, 1'b0);
      chk("xition_we",    32'(bus.tbl_we), 32'd1);
      chk("xition_addr",  32'(bus.tbl_addr), 32'(i + 1));
      chk("xition_wdata", 32'(bus.tbl_wdata), 32'(vexp[i]));
      chk("xition_cnt",   bus.mispred_cnt, vcnt[i]);
      tick();
    end

    // Ten back-to-back updates: simultaneous push/pop keeps ready high
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i), STRONGLY_TAKEN, 1'b1);
      chk("stream_ready", 32'(bus.upd_ready), 32'd1);
      if (i > 0) begin
        chk("stream_we",   32'(bus.tbl_we), 32'd1);
        chk("stream_addr", 32'(bus.tbl_addr), 32'(i - 1));
      end
      tick();
    end
    drive(1'b0, 4'd0, STRONGLY_UNTAKEN, 1'b0);
    chk("stream_last_we",    32'(bus.tbl_we), 32'd1);
    chk("stream_last_addr",  32'(bus.tbl_addr), 32'd9);
    chk("stream_last_wdata", 32'(bus.tbl_wdata), 32'(STRONGLY_TAKEN));
    tick();
    chk("stream_done_we", 32'(bus.tbl_we), 32'd0);
    chk("stream_cnt",     bus.mispred_cnt, 32'd5);

    // Flush with pending traffic; third push coincides with flush and is dropped
    drive(1'b1, 4'd10, WEAKLY_TAKEN, 1'b0);
    tick();
    drive(1'b1, 4'd11, WEAKLY_TAKEN, 1'b0);
    tick();
    drive(1'b1, 4'd12, WEAKLY_TAKEN, 1'b0);
    bus.flush_req = 1'b1;
    chk("flush_head_we",   32'(bus.tbl_we), 32'd1);
    chk("flush_head_addr", 32'(bus.tbl_addr), 32'd11);
    tick();
    drive(1'b0, 4'd0, STRONGLY_UNTAKEN, 1'b0);
    bus.flush_req = 1'b0;
    chk("flush_busy",  32'(bus.busy), 32'd1);
    chk("flush_addr",  32'(bus.tbl_addr), 32'd0);
    chk("flush_wdata", 32'(bus.tbl_wdata), 32'(WEAKLY_UNTAKEN));
    chk("flush_ready", 32'(bus.upd_ready), 32'd0);
    chk("flush_cnt",   bus.mispred_cnt, 32'd8);
    repeat (7) tick();
    chk("midsweep_addr", 32'(bus.tbl_addr), 32'd7);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    chk("reflush_addr", 32'(bus.tbl_addr), 32'd0);
    chk("reflush_busy", 32'(bus.busy), 32'd1);
    repeat (15) tick();
    chk("reflush_end_addr", 32'(bus.tbl_addr), 32'd15);
    chk("reflush_end_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("reflush_done_busy",  32'(bus.busy), 32'd0);
    chk("reflush_done_we",    32'(bus.tbl_we), 32'd0);
    chk("reflush_done_ready", 32'(bus.upd_ready), 32'd1);
    chk("reflush_done_cnt",   bus.mispred_cnt, 32'd8);

    // Counter saturation
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_cnt_q;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i), WEAKLY_TAKEN, 1'b0);
      tick();
      chk("sat_cnt", bus.mispred_cnt, 32'hFFFF_FFFF);
    end
    drive(1'b0, 4'd0, STRONGLY_UNTAKEN, 1'b0);
    tick();
    chk("sat_hold", bus.mispred_cnt, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
